// File: rtl/tft43_cmd_seq.sv
// tft43_cmd_seq: power-on reset, init command sequencing and user write
// arbitration for a 4.3" TFT panel behind a separate bus-timing stage.
// Optional backlight PWM is enabled by defining TFT43_BL_PWM_EN; without it
// the backlight is driven constantly on once init completes.
module tft43_cmd_seq #(
  parameter int unsigned RST_LOW_CYC  = 500000,
  parameter int unsigned RST_WAIT_CYC = 6000000,
  parameter int unsigned DLY_CMD_CYC  = 6000000,
  parameter int unsigned DONE_TO_CYC  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic [15:0] req_cmd,
  input  logic [15:0] req_data,
  input  logic [7:0]  bl_duty,
  output logic        o_en,
  output logic [1:0]  o_trigger,
  output logic [15:0] o_cmd,
  output logic [15:0] o_data,
  input  logic        i_done,
  output logic        o_lcd_rst,
  output logic        o_bl_ctr,
  output logic        o_init_done,
  output logic        o_err
);

  localparam int unsigned CNT_W    = 32;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned TRIG_W   = 2;
  localparam int unsigned WORD_W   = 16;
  localparam int unsigned LAST_IDX = 5;

  typedef enum logic [2:0] {
    RST_LO    = 3'd0,
    RST_WAIT  = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    DLY       = 3'd4,
    READY     = 3'd5,
    ERR       = 3'd6
  } state_t;

  state_t              state, stateNxt;
  logic [CNT_W-1:0]    cnt, cntNxt, cntInc;
  logic [IDX_W-1:0]    idx, idxNxt;
  logic                lcdRstNxt, initDoneNxt, errNxt, enNxt, readyNxt, blNxt;
  logic [TRIG_W-1:0]   trigNxt;
  logic [WORD_W-1:0]   cmdNxt, dataNxt;

  logic [TRIG_W-1:0]   romType;
  logic [WORD_W-1:0]   romCmd, romData;
  logic                romDly;

  assign cntInc = cnt + CNT_W'(1);

  // Init ROM: bus type, command, data and post-delay flag per entry
  always_comb begin
    romType = '0;
    romCmd  = '0;
    romData = '0;
    romDly  = 1'b0;
    case (idx)
      3'd0: begin romType = 2'b01; romCmd = 16'h0001; romDly = 1'b1; end
      3'd1: begin romType = 2'b01; romCmd = 16'h0011; romDly = 1'b1; end
      3'd2: begin romType = 2'b10; romCmd = 16'h003A; romData = 16'h0055; end
      3'd3: begin romType = 2'b10; romCmd = 16'h0036; romData = 16'h0000; end
      3'd4: begin romType = 2'b01; romCmd = 16'h0013; end
      3'd5: begin romType = 2'b01; romCmd = 16'h0029; end
      default: ;
    endcase
  end

  // State, counter and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RST_LO;
      cnt         <= '0;
      idx         <= '0;
      o_lcd_rst   <= 1'b0;
      o_en        <= 1'b0;
      o_trigger   <= '0;
      o_cmd       <= '0;
      o_data      <= '0;
      o_init_done <= 1'b0;
      o_err       <= 1'b0;
      req_ready   <= 1'b0;
      o_bl_ctr    <= 1'b0;
    end else begin
      state       <= stateNxt;
      cnt         <= cntNxt;
      idx         <= idxNxt;
      o_lcd_rst   <= lcdRstNxt;
      o_en        <= enNxt;
      o_trigger   <= trigNxt;
      o_cmd       <= cmdNxt;
      o_data      <= dataNxt;
      o_init_done <= initDoneNxt;
      o_err       <= errNxt;
      req_ready   <= readyNxt;
      o_bl_ctr    <= blNxt;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    stateNxt    = state;
    cntNxt      = cnt;
    idxNxt      = idx;
    lcdRstNxt   = o_lcd_rst;
    trigNxt     = o_trigger;
    cmdNxt      = o_cmd;
    dataNxt     = o_data;
    initDoneNxt = o_init_done;
    errNxt      = o_err;

    case (state)
      RST_LO: begin
        lcdRstNxt = 1'b0;
        if (cntInc >= CNT_W'(RST_LOW_CYC)) begin
          stateNxt  = RST_WAIT;
          cntNxt    = '0;
          lcdRstNxt = 1'b1;
        end else begin
          cntNxt = cntInc;
        end
      end

      RST_WAIT: begin
        if (cntInc >= CNT_W'(RST_WAIT_CYC)) begin
          stateNxt = ISSUE;
          cntNxt   = '0;
          idxNxt   = '0;
        end else begin
          cntNxt = cntInc;
        end
      end

      ISSUE: begin
        trigNxt  = romType;
        cmdNxt   = romCmd;
        dataNxt  = romData;
        cntNxt   = '0;
        stateNxt = WAIT_DONE;
      end

      WAIT_DONE: begin
        if (i_done) begin
          // Trigger drops for at least one cycle before any new transaction
          trigNxt = '0;
          cntNxt  = '0;
          if (o_init_done) begin
            stateNxt = READY;
          end else if (idx == IDX_W'(LAST_IDX)) begin
            initDoneNxt = 1'b1;
            stateNxt    = READY;
          end else begin
            idxNxt   = idx + IDX_W'(1);
            stateNxt = romDly ? DLY : ISSUE;
          end
        end else if (cntInc >= CNT_W'(DONE_TO_CYC)) begin
          trigNxt  = '0;
          errNxt   = 1'b1;
          cntNxt   = '0;
          stateNxt = ERR;
        end else begin
          cntNxt = cntInc;
        end
      end

      DLY: begin
        if (cntInc >= CNT_W'(DLY_CMD_CYC)) begin
          cntNxt   = '0;
          stateNxt = ISSUE;
        end else begin
          cntNxt = cntInc;
        end
      end

      READY: begin
        // Types 00/11 are accepted and dropped without touching the bus
        if (req_valid && req_ready && (req_type == 2'b01 || req_type == 2'b10)) begin
          trigNxt  = req_type;
          cmdNxt   = req_cmd;
          dataNxt  = req_data;
          cntNxt   = '0;
          stateNxt = WAIT_DONE;
        end
      end

      ERR: begin
        trigNxt = '0;
        errNxt  = 1'b1;
      end

      default: begin
        stateNxt = RST_LO;
        cntNxt   = '0;
      end
    endcase

    enNxt    = (stateNxt == ISSUE) || (stateNxt == WAIT_DONE) ||
               (stateNxt == DLY)   || (stateNxt == READY);
    readyNxt = (stateNxt == READY);
  end

`ifdef TFT43_BL_PWM_EN
  logic [7:0] pwmCnt;

  // Free-running PWM phase counter, started once init is complete
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwmCnt <= '0;
    end else if (o_init_done) begin
      pwmCnt <= pwmCnt + 8'(1);
    end
  end

  // Backlight high while phase is below the requested duty
  always_comb begin
    blNxt = o_init_done && (pwmCnt < bl_duty);
  end
`else
  logic unusedBlDuty;
  assign unusedBlDuty = ^bl_duty;

  // Backlight fully on as soon as init is complete
  always_comb begin
    blNxt = initDoneNxt;
  end
`endif

endmodule

// File: tb/tb_tft43_cmd_seq.sv
// Directed bench for tft43_cmd_seq: init sequence, user requests from a
// vector table, done timeout, mid-init reset and backlight drive.
module tb_tft43_cmd_seq;

  localparam int unsigned RST_LOW  = 4;
  localparam int unsigned RST_WAIT = 8;
  localparam int unsigned DLY_CYC  = 16;
  localparam int unsigned DONE_TO  = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_type = 2'b00;
  logic [15:0] req_cmd = '0;
  logic [15:0] req_data = '0;
  logic [7:0]  bl_duty = 8'h80;
  logic        o_en;
  logic [1:0]  o_trigger;
  logic [15:0] o_cmd;
  logic [15:0] o_data;
  logic        i_done;
  logic        o_lcd_rst, o_bl_ctr, o_init_done, o_err;

  logic        modelDone = 1'b0;
  logic        forceDone = 1'b0;
  logic        muteEn = 1'b0;
  logic [15:0] muteCmd = 16'h003A;
  int          age = 0;
  int          tests = 0;
  int          fails = 0;

  assign i_done = modelDone | forceDone;

  tft43_cmd_seq #(
    .RST_LOW_CYC (RST_LOW),
    .RST_WAIT_CYC(RST_WAIT),
    .DLY_CMD_CYC (DLY_CYC),
    .DONE_TO_CYC (DONE_TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_type   (req_type),
    .req_cmd    (req_cmd),
    .req_data   (req_data),
    .bl_duty    (bl_duty),
    .o_en       (o_en),
    .o_trigger  (o_trigger),
    .o_cmd      (o_cmd),
    .o_data     (o_data),
    .i_done     (i_done),
    .o_lcd_rst  (o_lcd_rst),
    .o_bl_ctr   (o_bl_ctr),
    .o_init_done(o_init_done),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  // Bus-timing stage model: done pulse three cycles after trigger rises
  always @(negedge clk) begin
    if (o_trigger != 2'b00) age = age + 1;
    else age = 0;
    modelDone = (age == 3) && !(muteEn && o_cmd == muteCmd);
  end

  typedef struct {
    logic [1:0]  typ;
    logic [15:0] cmd;
    logic [15:0] data;
    logic [1:0]  expTrig;
    logic [15:0] expCmd;
    logic [15:0] expData;
    logic        expReady;
  } vec_t;

  vec_t        vecs[5];
  logic [1:0]  romT[6];
  logic [15:0] romC[6];
  logic [15:0] romD[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitCmd(input logic [15:0] cmd, input string name);
    int n;
    n = 0;
    while (!(o_trigger != 2'b00 && o_cmd == cmd) && n < 300) begin
      tick;
      n++;
    end
    check(name, 32'(o_cmd), 32'(cmd));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int hi;

    romT = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
    romC = '{16'h0001, 16'h0011, 16'h003A, 16'h0036, 16'h0013, 16'h0029};
    romD = '{16'h0000, 16'h0000, 16'h0055, 16'h0000, 16'h0000, 16'h0000};

    vecs[0] = '{2'b10, 16'h002C, 16'hF800, 2'b10, 16'h002C, 16'hF800, 1'b0};
    vecs[1] = '{2'b01, 16'h0029, 16'h1234, 2'b01, 16'h0029, 16'h1234, 1'b0};
    vecs[2] = '{2'b11, 16'hAAAA, 16'h5555, 2'b00, 16'h0029, 16'h1234, 1'b1};
    vecs[3] = '{2'b00, 16'hBBBB, 16'h6666, 2'b00, 16'h0029, 16'h1234, 1'b1};
    vecs[4] = '{2'b10, 16'hFFFF, 16'h0000, 2'b10, 16'hFFFF, 16'h0000, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          32'({o_lcd_rst, o_bl_ctr, o_en, o_trigger, o_cmd, o_data, o_init_done, o_err, req_ready}),
          32'(0));

    // Power-on reset timing
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin tick; n++; end while (o_lcd_rst == 1'b0 && n < 50);
    check("lcd_rst_low_cycles", 32'(n), 32'(RST_LOW));
    n = 0;
    do begin tick; n++; end while (o_trigger == 2'b00 && n < 50);
    check("rst_wait_to_first_trig", 32'(n), 32'(RST_WAIT + 1));
    check("bl_off_during_init", 32'(o_bl_ctr), 32'(0));
    check("en_during_init", 32'(o_en), 32'(1));

    // Init ROM walk
    for (int i = 0; i < 6; i++) begin
      check($sformatf("init%0d_trig", i), 32'(o_trigger), 32'(romT[i]));
      check($sformatf("init%0d_cmd", i), 32'(o_cmd), 32'(romC[i]));
      check($sformatf("init%0d_data", i), 32'(o_data), 32'(romD[i]));
      n = 0;
      do begin tick; n++; end while (o_trigger != 2'b00 && n < 30);
      check($sformatf("init%0d_release", i), 32'(n), 32'(3));
      if (i < 5) begin
        n = 0;
        do begin tick; n++; end while (o_trigger == 2'b00 && n < 60);
        check($sformatf("init%0d_gap", i), 32'(n), (i < 2) ? 32'(DLY_CYC + 1) : 32'(1));
      end else begin
        check("init_done", 32'(o_init_done), 32'(1));
        check("ready_after_init", 32'(req_ready), 32'(1));
`ifndef TFT43_BL_PWM_EN
        check("bl_on_after_init", 32'(o_bl_ctr), 32'(1));
`endif
      end
    end

    // User requests from the vector table
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_type  = vecs[v].typ;
      req_cmd   = vecs[v].cmd;
      req_data  = vecs[v].data;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check($sformatf("vec%0d_trig", v), 32'(o_trigger), 32'(vecs[v].expTrig));
      check($sformatf("vec%0d_cmd", v), 32'(o_cmd), 32'(vecs[v].expCmd));
      check($sformatf("vec%0d_data", v), 32'(o_data), 32'(vecs[v].expData));
      check($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(vecs[v].expReady));
      if (vecs[v].expTrig != 2'b00) begin
        n = 0;
        do begin tick; n++; end while (req_ready == 1'b0 && n < 30);
        check($sformatf("vec%0d_return", v), 32'(n), 32'(3));
        check($sformatf("vec%0d_trig_idle", v), 32'(o_trigger), 32'(0));
      end else begin
        tick;
        check($sformatf("vec%0d_no_trig", v), 32'(o_trigger), 32'(0));
      end
    end

    // Stray done pulse in READY
    @(negedge clk);
    forceDone = 1'b1;
    tick;
    forceDone = 1'b0;
    tick;
    check("stray_done_trig", 32'(o_trigger), 32'(0));
    check("stray_done_ready", 32'(req_ready), 32'(1));
    check("stray_done_err", 32'(o_err), 32'(0));

    // Backlight drive
`ifdef TFT43_BL_PWM_EN
    @(negedge clk);
    bl_duty = 8'h40;
    tick;
    tick;
    hi = 0;
    repeat (256) begin tick; hi += int'(o_bl_ctr); end
    check("pwm_duty_40", 32'(hi), 32'(64));
    @(negedge clk);
    bl_duty = 8'h00;
    tick;
    tick;
    hi = 0;
    repeat (256) begin tick; hi += int'(o_bl_ctr); end
    check("pwm_duty_00", 32'(hi), 32'(0));
`else
    @(negedge clk);
    bl_duty = 8'h00;
    tick;
    hi = 0;
    repeat (256) begin tick; hi += int'(o_bl_ctr); end
    check("bl_constant_on", 32'(hi), 32'(256));
`endif

    // Asynchronous reset during init entry 3
    pulseReset;
    waitCmd(16'h0036, "reach_entry3");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({o_lcd_rst, o_bl_ctr, o_en, o_trigger, o_cmd, o_data, o_init_done, o_err, req_ready}),
          32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin tick; n++; end while (o_trigger == 2'b00 && n < 50);
    check("restart_first_cmd", 32'(o_cmd), 32'h0001);
    check("restart_first_trig", 32'(o_trigger), 32'(2'b01));

    // Done timeout on init entry 2
    muteEn = 1'b1;
    pulseReset;
    waitCmd(16'h003A, "reach_entry2");
    n = 0;
    do begin tick; n++; end while (o_err == 1'b0 && n < 40);
    check("timeout_cycles", 32'(n), 32'(DONE_TO));
    check("err_trig", 32'(o_trigger), 32'(0));
    check("err_en", 32'(o_en), 32'(0));
    check("err_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    req_valid = 1'b1;
    req_type  = 2'b10;
    repeat (5) tick;
    req_valid = 1'b0;
    check("err_sticky", 32'(o_err), 32'(1));
    check("err_ready_held", 32'(req_ready), 32'(0));
    check("err_trig_held", 32'(o_trigger), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
